// File: rtl/lattice_history_port_arbiter.sv
// Single-port history BRAM arbiter: FSM write stream vs two round-robin readers.
// A starvation limit plus a 1-entry write skid keeps both readers moving.
module lattice_history_port_arbiter #(
    parameter int ADDR_BITS     = 7,
    parameter int DATA_BITS     = 32,
    parameter int STARVE_LIMIT  = 4,
    parameter int DROP_CNT_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [ADDR_BITS-1:0]     wr_addr,
    input  logic [DATA_BITS-1:0]     wr_data,
    input  logic                     rd0_valid,
    input  logic [ADDR_BITS-1:0]     rd0_addr,
    output logic                     rd0_ready,
    output logic                     rd0_rvalid,
    output logic [DATA_BITS-1:0]     rd0_rdata,
    input  logic                     rd1_valid,
    input  logic [ADDR_BITS-1:0]     rd1_addr,
    output logic                     rd1_ready,
    output logic                     rd1_rvalid,
    output logic [DATA_BITS-1:0]     rd1_rdata,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic [ADDR_BITS-1:0]     mem_addr,
    output logic [DATA_BITS-1:0]     mem_wdata,
    input  logic [DATA_BITS-1:0]     mem_rdata,
    output logic                     wr_drop,
    output logic [DROP_CNT_BITS-1:0] drop_count,
    output logic                     skid_full
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]               starve_cnt;
    logic                     skid_q;
    logic [ADDR_BITS-1:0]     skid_addr;
    logic [DATA_BITS-1:0]     skid_data;
    logic                     rr_last;
    logic                     rvalid0_q;
    logic                     rvalid1_q;
    logic                     fwd_q;
    logic [DATA_BITS-1:0]     fwd_data_q;
    logic                     drop_q;
    logic [DROP_CNT_BITS-1:0] drop_cnt_q;

    logic                 any_rd;
    logic                 starved;
    logic                 drain;
    logic                 direct;
    logic                 rd_go;
    logic                 gnt0;
    logic                 gnt1;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 skid_load;
    logic                 drop;
    logic                 fwd_wr;
    logic                 fwd_skid;
    logic [DATA_BITS-1:0] rsp_data;

    always_comb begin
        any_rd    = rd0_valid | rd1_valid;
        starved   = any_rd && (starve_cnt >= LIMIT);
        drain     = skid_q && !starved;
        direct    = wr_valid && !skid_q && !starved;
        rd_go     = any_rd && !drain && !direct;
        gnt1      = rd_go && rd1_valid && (!rd0_valid || !rr_last);
        gnt0      = rd_go && rd0_valid && !gnt1;
        rd_addr   = gnt1 ? rd1_addr : rd0_addr;
        // A write that cannot reach the port parks in the skid, else it is lost
        skid_load = wr_valid && (drain || (rd_go && !skid_q));
        drop      = wr_valid && rd_go && skid_q;
        // The write parked this cycle is newer than anything already in the skid
        fwd_wr    = rd_go && skid_load && (wr_addr == rd_addr);
        fwd_skid  = rd_go && skid_q && (skid_addr == rd_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            skid_q     <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
            rr_last    <= 1'b1;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
            drop_q    <= drop;
            if (rd_go) begin
                fwd_q      <= fwd_wr | fwd_skid;
                fwd_data_q <= fwd_wr ? wr_data : skid_data;
            end
            if (gnt0) begin
                rr_last <= 1'b0;
            end else if (gnt1) begin
                rr_last <= 1'b1;
            end
            if (skid_load) begin
                skid_q    <= 1'b1;
                skid_addr <= wr_addr;
                skid_data <= wr_data;
            end else if (drain) begin
                skid_q <= 1'b0;
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
            if (!any_rd || rd_go) begin
                starve_cnt <= '0;
            end else if (starve_cnt < LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        rsp_data   = fwd_q ? fwd_data_q : mem_rdata;
        rd0_ready  = gnt0;
        rd1_ready  = gnt1;
        rd0_rvalid = rvalid0_q;
        rd1_rvalid = rvalid1_q;
        rd0_rdata  = rvalid0_q ? rsp_data : '0;
        rd1_rdata  = rvalid1_q ? rsp_data : '0;
        mem_we     = drain | direct;
        mem_re     = rd_go;
        mem_addr   = drain ? skid_addr : (direct ? wr_addr : rd_addr);
        mem_wdata  = drain ? skid_data : wr_data;
        wr_drop    = drop_q;
        drop_count = drop_cnt_q;
        skid_full  = skid_q;
    end

endmodule
